// File: rtl/mb_drive_arb.sv
// rtl/mb_drive_arb.sv - Massbus drive arbiter: round-robin grant, burst limit, no-ack timeout, attention summary
//
// Arbitrates per-drive transfer requests onto the single RH11 devREQO/devACKI
// handshake. A grant lasts at most BURST words; each word is a REQ cycle (or
// several, while waiting for devACKI) followed by one GAP cycle that gives the
// drive a chance to update drvREQ. A REQ that waits TIMEOUT cycles without an
// acknowledge is abandoned and reported on tmoERR/tmoUNIT.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   drvREQ/drvACK     per-drive request in, per-drive one-cycle acknowledge out
//   drvDATAO          per-drive 36-bit data, drive i at [36*i +: 36]
//   drvATA            per-drive attention set pulses
//   devREQO/devACKI   handshake to/from the RH11
//   devDATAO          data of the granted drive while requesting, else 0
//   grantVALID/UNIT   current grant holder
//   mbWRREG16/mbDATA  write-one-to-clear access to the attention summary
//   rhAS/intrATA      attention summary and its OR
//   tmoERR/tmoUNIT    timeout pulse and the drive that last timed out
module mb_drive_arb #(
    parameter int NDRV    = 8,
    parameter int BURST   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NDRV-1:0]      drvREQ,
    output logic [NDRV-1:0]      drvACK,
    input  logic [36*NDRV-1:0]   drvDATAO,
    input  logic [NDRV-1:0]      drvATA,
    output logic                 devREQO,
    input  logic                 devACKI,
    output logic [35:0]          devDATAO,
    output logic                 grantVALID,
    output logic [3:0]           grantUNIT,
    input  logic                 mbWRREG16,
    input  logic [15:0]          mbDATA,
    output logic [15:0]          rhAS,
    output logic                 intrATA,
    output logic                 tmoERR,
    output logic [3:0]           tmoUNIT
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  last_q, last_d;
    logic [3:0]  unit_q, unit_d;
    logic [3:0]  tmo_unit_q, tmo_unit_d;
    logic        gv_q, gv_d;
    logic [7:0]  words_q, words_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic [15:0] as_q, as_d;

    // Drive-indexed vectors widened to 16 so a 4-bit unit number indexes them.
    logic [15:0] req_ext;
    logic [15:0] ata_ext;
    logic [15:0] as_mask;
    logic [3:0]  pick;
    logic        pick_ok;
    logic [4:0]  idx;
    logic        in_req;
    logic        tmo_hit;

    always_comb begin
        req_ext = '0;
        ata_ext = '0;
        as_mask = '0;
        req_ext[NDRV-1:0] = drvREQ;
        ata_ext[NDRV-1:0] = drvATA;
        as_mask[NDRV-1:0] = '1;
    end

    // Round-robin: scan from the drive after last, wrapping modulo NDRV.
    always_comb begin
        pick    = last_q;
        pick_ok = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NDRV; k++) begin
            idx = {1'b0, last_q} + 5'(k);
            if (idx >= 5'(NDRV)) begin
                idx = idx - 5'(NDRV);
            end
            if (!pick_ok && req_ext[idx[3:0]]) begin
                pick_ok = 1'b1;
                pick    = idx[3:0];
            end
        end
    end

    // A cycle with rst asserted never shows a handshake, so an acknowledge or
    // timeout racing a reset is dropped rather than half-reported.
    assign in_req  = (state_q == S_REQ) && !rst;
    assign tmo_hit = (tmo_cnt_q == 16'(TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        unit_d     = unit_q;
        tmo_unit_d = tmo_unit_q;
        gv_d       = gv_q;
        words_d    = words_q;
        tmo_cnt_d  = tmo_cnt_q;
        // Set wins over a simultaneous clear.
        as_d = (ata_ext | (as_q & ~(mbWRREG16 ? mbDATA : 16'h0000))) & as_mask;
        case (state_q)
            S_IDLE: begin
                if (pick_ok) begin
                    unit_d    = pick;
                    last_d    = pick;
                    gv_d      = 1'b1;
                    words_d   = '0;
                    tmo_cnt_d = '0;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                if (devACKI) begin
                    words_d = words_q + 8'd1;
                    state_d = S_GAP;
                end else if (tmo_hit) begin
                    tmo_unit_d = unit_q;
                    gv_d       = 1'b0;
                    state_d    = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            S_GAP: begin
                if (req_ext[unit_q] && (words_q < 8'(BURST))) begin
                    tmo_cnt_d = '0;
                    state_d   = S_REQ;
                end else begin
                    gv_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                gv_d    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            last_q     <= 4'(NDRV - 1);
            unit_q     <= '0;
            tmo_unit_q <= '0;
            gv_q       <= 1'b0;
            words_q    <= '0;
            tmo_cnt_q  <= '0;
            as_q       <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            unit_q     <= unit_d;
            tmo_unit_q <= tmo_unit_d;
            gv_q       <= gv_d;
            words_q    <= words_d;
            tmo_cnt_q  <= tmo_cnt_d;
            as_q       <= as_d;
        end
    end

    always_comb begin
        drvACK   = '0;
        devDATAO = '0;
        for (int i = 0; i < NDRV; i++) begin
            if (in_req && (unit_q == 4'(i))) begin
                drvACK[i] = devACKI;
                devDATAO  = drvDATAO[36*i +: 36];
            end
        end
    end

    assign devREQO    = in_req;
    assign tmoERR     = in_req && !devACKI && tmo_hit;
    assign grantVALID = gv_q;
    assign grantUNIT  = unit_q;
    assign tmoUNIT    = tmo_unit_q;
    assign rhAS       = as_q;
    assign intrATA    = |as_q;

endmodule

// File: tb/tb_mb_drive_arb.sv
// tb/tb_mb_drive_arb.sv - self-checking bench for mb_drive_arb against a behavioural model
module tb_mb_drive_arb;

    localparam int N = 8;
    localparam int B = 4;
    localparam int T = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic [N-1:0]      drv_req = '0;
    logic [N-1:0]      drv_ack;
    logic [36*N-1:0]   drv_data = '0;
    logic [N-1:0]      drv_ata = '0;
    logic              dev_req;
    logic              dev_ack = 1'b0;
    logic [35:0]       dev_data;
    logic              gv;
    logic [3:0]        gu;
    logic              wr = 1'b0;
    logic [15:0]       wdata = '0;
    logic [15:0]       as_o;
    logic              intr;
    logic              tmo;
    logic [3:0]        tu;

    // Second instance: single drive, burst of two.
    logic [0:0]  req1 = 1'b0;
    logic [0:0]  ack1_o;
    logic [35:0] data1 = 36'h123456789;
    logic [0:0]  ata1 = 1'b0;
    logic        dev_req1;
    logic        dev_ack1 = 1'b0;
    logic [35:0] dev_data1;
    logic        gv1;
    logic [3:0]  gu1;
    logic [15:0] as1;
    logic        intr1;
    logic        tmo1;
    logic [3:0]  tu1;

    mb_drive_arb #(.NDRV(N), .BURST(B), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .drvREQ(drv_req), .drvACK(drv_ack), .drvDATAO(drv_data),
        .drvATA(drv_ata), .devREQO(dev_req), .devACKI(dev_ack), .devDATAO(dev_data),
        .grantVALID(gv), .grantUNIT(gu), .mbWRREG16(wr), .mbDATA(wdata), .rhAS(as_o),
        .intrATA(intr), .tmoERR(tmo), .tmoUNIT(tu)
    );

    mb_drive_arb #(.NDRV(1), .BURST(2), .TIMEOUT(T)) dut1 (
        .clk(clk), .rst(rst), .drvREQ(req1), .drvACK(ack1_o), .drvDATAO(data1),
        .drvATA(ata1), .devREQO(dev_req1), .devACKI(dev_ack1), .devDATAO(dev_data1),
        .grantVALID(gv1), .grantUNIT(gu1), .mbWRREG16(1'b0), .mbDATA(16'h0000), .rhAS(as1),
        .intrATA(intr1), .tmoERR(tmo1), .tmoUNIT(tu1)
    );

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit bit_of(input logic [15:0] v, input int i);
        return v[i[3:0]];
    endfunction

    // Behavioural model: who owns the bus, how far into the burst, how long
    // the current request has waited. phase 0 = arbitrating, 1 = word
    // requested, 2 = turnaround after a word.
    int          m_phase = 0;
    int          m_owner = 0;
    int          m_last = N - 1;
    int          m_words = 0;
    int          m_wait = 0;
    logic        m_gv = 1'b0;
    logic [3:0]  m_gu = '0;
    logic [3:0]  m_tu = '0;
    logic [15:0] m_as = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_owner = 0; m_last = N - 1; m_words = 0; m_wait = 0;
            m_gv = 1'b0; m_gu = '0; m_tu = '0; m_as = '0;
        end else begin
            m_as = (m_as & ~(wr ? wdata : 16'h0000)) | 16'(drv_ata);
            case (m_phase)
                0: if (drv_req != '0) begin
                    for (int k = 1; k <= N; k++) begin
                        int d;
                        d = (m_last + k) % N;
                        if (bit_of(16'(drv_req), d)) begin
                            m_owner = d;
                            break;
                        end
                    end
                    m_last = m_owner; m_gu = 4'(m_owner); m_gv = 1'b1;
                    m_words = 0; m_wait = 0; m_phase = 1;
                end
                1: if (dev_ack) begin
                    m_words = m_words + 1; m_phase = 2;
                end else if (m_wait == T - 1) begin
                    m_tu = 4'(m_owner); m_gv = 1'b0; m_phase = 0;
                end else begin
                    m_wait = m_wait + 1;
                end
                default: if (bit_of(16'(drv_req), m_owner) && m_words < B) begin
                    m_wait = 0; m_phase = 1;
                end else begin
                    m_gv = 1'b0; m_phase = 0;
                end
            endcase
        end
    end

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            bit            in_req;
            logic [N-1:0]  e_ack;
            logic [36*N-1:0] sh;
            logic [35:0]   e_data;
            in_req = !rst && (m_phase == 1);
            e_ack  = '0;
            e_data = '0;
            if (in_req && dev_ack) e_ack = N'(1) << m_owner;
            if (in_req) begin
                sh = drv_data >> (36 * m_owner);
                e_data = sh[35:0];
            end
            chk("devREQO", 64'(dev_req), 64'(in_req));
            chk("drvACK", 64'(drv_ack), 64'(e_ack));
            chk("devDATAO", 64'(dev_data), 64'(e_data));
            chk("grantVALID", 64'(gv), 64'(m_gv));
            chk("grantUNIT", 64'(gu), 64'(m_gu));
            chk("tmoERR", 64'(tmo), 64'(in_req && !dev_ack && m_wait == T - 1));
            chk("tmoUNIT", 64'(tu), 64'(m_tu));
            chk("rhAS", 64'(as_o), 64'(m_as));
            chk("intrATA", 64'(intr), 64'(m_as != 16'h0));
        end
    end

    // Grant log taken from DUT outputs, for the literal sequence checks.
    int   g_units[$];
    int   g_acks[$];
    int   req_pulses = 0;
    logic prev_gv = 1'b0;
    logic prev_req = 1'b0;

    always @(negedge clk) begin
        if (gv && !prev_gv) begin
            g_units.push_back(int'(gu));
            g_acks.push_back(0);
        end
        if (drv_ack != '0 && g_acks.size() > 0) g_acks[g_acks.size() - 1] += 1;
        if (dev_req && !prev_req) req_pulses++;
        prev_gv  = gv;
        prev_req = dev_req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 36 * N; i++) drv_data[i] = 1'($urandom);
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        g_units.delete();
        g_acks.delete();
        req_pulses = 0;
    endtask

    logic [6:0] pat;
    bit         found;
    int         n_reqc;

    initial begin
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        sample();
        chk("reset_grantVALID", 64'(gv), 64'd0);
        chk("reset_devREQO", 64'(dev_req), 64'd0);
        chk("reset_rhAS", 64'(as_o), 64'd0);
        rst = 1'b0;

        // Two drives, zero-wait RH11; single-drive instance in parallel.
        tick();
        clear_logs();
        drv_req = 8'h05; dev_ack = 1'b1;
        req1 = 1'b1; dev_ack1 = 1'b1;
        for (int c = 0; c < 27; c++) begin
            sample();
            if (c < 7) pat[c] = dev_req1;
            tick();
        end
        drv_req = '0;
        repeat (6) tick();
        chk("single_drive_pattern", 64'(pat), 64'(7'b1001010));
        chk("single_drive_unit", 64'(gu1), 64'd0);
        chk("grant_count", 64'(g_units.size() >= 3), 64'd1);
        if (g_units.size() >= 3) begin
            chk("grant0_unit", 64'(g_units[0]), 64'd0);
            chk("grant1_unit", 64'(g_units[1]), 64'd2);
            chk("grant2_unit", 64'(g_units[2]), 64'd0);
            chk("grant0_acks", 64'(g_acks[0]), 64'd4);
            chk("grant1_acks", 64'(g_acks[1]), 64'd4);
            chk("grant2_acks", 64'(g_acks[2]), 64'd4);
        end

        // Drive 3 transfers a single word.
        clear_logs();
        drv_req = 8'h08;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            sample();
            if (drv_ack[3]) found = 1'b1;
            else tick();
        end
        chk("one_word_ack_seen", 64'(found), 64'd1);
        tick();
        drv_req = '0;
        sample();
        chk("one_word_gv_in_gap", 64'(gv), 64'd1);
        tick();
        sample();
        chk("one_word_gv_after_gap", 64'(gv), 64'd0);
        repeat (3) tick();
        chk("one_word_grants", 64'(g_units.size()), 64'd1);
        if (g_units.size() == 1) begin
            chk("one_word_unit", 64'(g_units[0]), 64'd3);
            chk("one_word_acks", 64'(g_acks[0]), 64'd1);
        end
        chk("one_word_req_pulses", 64'(req_pulses), 64'd1);

        // Timeout on drive 5.
        clear_logs();
        dev_ack = 1'b0;
        drv_req = 8'h20;
        found = 1'b0;
        n_reqc = 0;
        for (int c = 0; c < 60 && !found; c++) begin
            sample();
            if (dev_req) n_reqc++;
            if (tmo) found = 1'b1;
            else tick();
        end
        chk("tmo_seen", 64'(found), 64'd1);
        chk("tmo_req_cycles", 64'(n_reqc), 64'd16);
        tick();
        sample();
        chk("tmo_unit", 64'(tu), 64'd5);
        chk("tmo_idle_req", 64'(dev_req), 64'd0);
        chk("tmo_idle_gv", 64'(gv), 64'd0);
        tick();
        sample();
        chk("tmo_regrant_req", 64'(dev_req), 64'd1);
        chk("tmo_regrant_unit", 64'(gu), 64'd5);
        if (g_acks.size() > 0) chk("tmo_no_ack", 64'(g_acks[0]), 64'd0);
        dev_ack = 1'b1;
        tick();
        drv_req = '0;
        repeat (4) tick();

        // Attention summary.
        drv_ata = 8'h81; tick(); drv_ata = '0;
        sample();
        chk("as_set", 64'(as_o), 64'h81);
        chk("as_intr_set", 64'(intr), 64'd1);
        wr = 1'b1; wdata = 16'h0001; tick(); wr = 1'b0;
        sample();
        chk("as_clr0", 64'(as_o), 64'h80);
        drv_ata = 8'h80; wr = 1'b1; wdata = 16'h0080; tick(); drv_ata = '0; wr = 1'b0;
        sample();
        chk("as_set_wins", 64'(as_o), 64'h80);
        wr = 1'b1; wdata = 16'h0080; tick(); wr = 1'b0;
        sample();
        chk("as_clr7", 64'(as_o), 64'h0);
        chk("as_intr_clr", 64'(intr), 64'd0);

        // Reset during a request from drive 1 with an acknowledge arriving.
        drv_ata = 8'h10; tick(); drv_ata = '0;
        dev_ack = 1'b0;
        drv_req = 8'h02;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            sample();
            if (dev_req && gu == 4'd1) found = 1'b1;
            else tick();
        end
        chk("rst_req_found", 64'(found), 64'd1);
        tick();
        rst = 1'b1; dev_ack = 1'b1;
        sample();
        chk("rst_no_ack", 64'(drv_ack), 64'd0);
        chk("rst_no_tmo", 64'(tmo), 64'd0);
        tick();
        rst = 1'b0; drv_req = 8'h03;
        sample();
        chk("rst_gv", 64'(gv), 64'd0);
        chk("rst_gu", 64'(gu), 64'd0);
        chk("rst_devreq", 64'(dev_req), 64'd0);
        chk("rst_devdata", 64'(dev_data), 64'd0);
        chk("rst_as", 64'(as_o), 64'd0);
        chk("rst_tu", 64'(tu), 64'd0);
        tick();
        sample();
        chk("rst_next_gv", 64'(gv), 64'd1);
        chk("rst_next_unit", 64'(gu), 64'd0);
        drv_req = '0;
        repeat (12) tick();

        // Randomized traffic with alternating fast and stalling RH11.
        for (int c = 0; c < 3000; c++) begin
            bit slow;
            slow = ((c / 200) % 2) == 1;
            if ($urandom_range(0, 3) == 0) drv_req = N'($urandom & $urandom);
            dev_ack = slow ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) != 0);
            drv_ata = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
            wr = ($urandom_range(0, 7) == 0);
            wdata = 16'($urandom);
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0; drv_req = '0; dev_ack = 1'b0; drv_ata = '0; wr = 1'b0;
        repeat (3) tick();
        sample();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
